// File: rtl/bp_resolve_queue_pkg.sv
// Shared types for the branch-prediction resolve queue.
//   addr_t       : 32-bit instruction address
//   bpq_entry_t  : fetch-time prediction held per fetch packet
//   bpq_state_e  : resolve FSM states
package bp_resolve_queue_pkg;

  localparam int unsigned BPQ_DEPTH = 8;
  localparam int unsigned ADDR_W    = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    addr_t pc;      // packet base pc
    logic  taken;   // predicted taken
    logic  pos;     // 0: slot pc, 1: slot pc+4
    addr_t pre_pc;  // predicted target
  } bpq_entry_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    WAIT     = 2'd2
  } bpq_state_e;

endpackage

// File: rtl/bp_resolve_queue_check.sv
// Combinational prediction check for one executing instruction.
//   entry       : prediction stored for the instruction's packet
//   res_pc      : pc of the executing instruction
//   ctrl        : instruction is any control-transfer class
//   res_taken   : actual direction
//   res_dest_pc : actual target
//   mis_c       : prediction disagrees with the actual outcome
//   next_pc_c   : correct next fetch pc
module bpq_check
  import bp_resolve_queue_pkg::*;
(
  input  bpq_entry_t entry,
  input  addr_t      res_pc,
  input  logic       ctrl,
  input  logic       res_taken,
  input  addr_t      res_dest_pc,
  output logic       mis_c,
  output addr_t      next_pc_c
);

  addr_t slot_pc;
  logic  pred_taken;

  // The prediction only applies to the slot it was made for.
  always_comb begin
    slot_pc    = entry.pc + (entry.pos ? addr_t'(4) : addr_t'(0));
    pred_taken = entry.taken && (res_pc == slot_pc);

    // Not-taken control transfers skip their delay slot.
    if (res_taken) begin
      next_pc_c = res_dest_pc;
    end else if (ctrl) begin
      next_pc_c = res_pc + addr_t'(8);
    end else begin
      next_pc_c = res_pc + addr_t'(4);
    end

    mis_c = (pred_taken != res_taken) ||
            (pred_taken && (entry.pre_pc != res_dest_pc));
  end

endmodule

// File: rtl/bp_resolve_queue.sv
// Execute-side resolve queue for branch predictions.
// Holds one prediction per fetch packet in allocation order, checks executing
// instructions against them, issues a one-shot redirect on a mispredict
// (rewinding younger packets) and drives registered predictor updates.
//   alloc_*    : in-order allocation from fetch, alloc_tag is the slot written
//   res_*      : executing instruction, tagged with its packet
//   free_valid : head packet retired from exe
//   fetch_restart : fetch accepted the redirect pc
//   redirect_* : one-cycle redirect pulse and correct pc
//   upd_*      : registered predictor update for control instructions
//   full/empty : occupancy status
module bp_resolve_queue
  import bp_resolve_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = BPQ_DEPTH,
  localparam int unsigned TAG_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = TAG_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [31:0]      alloc_pc,
  input  logic             alloc_taken,
  input  logic             alloc_pos,
  input  logic [31:0]      alloc_pre_pc,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic [31:0]      res_pc,
  input  logic             res_is_branch,
  input  logic             res_is_j,
  input  logic             res_is_jal,
  input  logic             res_is_jalr,
  input  logic             res_is_jr_ra,
  input  logic             res_taken,
  input  logic [31:0]      res_dest_pc,
  input  logic             free_valid,
  input  logic             fetch_restart,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             upd_is_branch,
  output logic             upd_is_j,
  output logic             upd_is_jal,
  output logic             upd_is_jalr,
  output logic             upd_is_jr_ra_exe,
  output logic             upd_is_taken,
  output logic [31:0]      upd_exe_pc,
  output logic [31:0]      upd_dest_pc,
  output logic [31:0]      upd_ret_pc,
  output logic             full,
  output logic             empty
);

  bpq_entry_t       entries [DEPTH];
  bpq_state_e       state, state_nxt;
  logic [TAG_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  bpq_entry_t       entry_c;
  logic             ctrl_c, check_en_c, rewind_c, upd_en_c;
  logic             alloc_fire_c, free_fire_c;
  logic             mis_c;
  addr_t            next_pc_c;
  logic [TAG_W-1:0] dist_c;
  logic [CNT_W-1:0] rewind_cnt_c;

  // Status derived from registered occupancy and state.
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign alloc_ready = !full && (state == RUN);
  assign alloc_tag   = tail;

  // Checks only run on the correct path; REDIRECT/WAIT traffic is wrong-path.
  always_comb begin
    entry_c      = entries[res_tag];
    ctrl_c       = res_is_branch | res_is_j | res_is_jal | res_is_jalr | res_is_jr_ra;
    check_en_c   = res_valid && (state == RUN);
    rewind_c     = check_en_c && mis_c;
    upd_en_c     = check_en_c && ctrl_c;
    alloc_fire_c = alloc_valid && alloc_ready;
    free_fire_c  = free_valid && !empty;
    // Occupancy after rewind keeps head..res_tag inclusive (1..DEPTH).
    dist_c       = res_tag - head;
    rewind_cnt_c = CNT_W'(dist_c) + CNT_W'(1);
  end

  bpq_check u_check (
    .entry       (entry_c),
    .res_pc      (res_pc),
    .ctrl        (ctrl_c),
    .res_taken   (res_taken),
    .res_dest_pc (res_dest_pc),
    .mis_c       (mis_c),
    .next_pc_c   (next_pc_c)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:      if (rewind_c) state_nxt = REDIRECT;
      REDIRECT: state_nxt = WAIT;
      WAIT:     if (fetch_restart) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Prediction storage; written only on an accepted allocation.
  always_ff @(posedge clk) begin
    if (alloc_fire_c && !rewind_c) begin
      entries[tail] <= '{pc: alloc_pc, taken: alloc_taken, pos: alloc_pos,
                         pre_pc: alloc_pre_pc};
    end
  end

  // Pointers and occupancy; a rewind drops same-cycle alloc, free applies after it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (rewind_c) begin
        tail  <= res_tag + TAG_W'(1);
        count <= free_fire_c ? rewind_cnt_c - CNT_W'(1) : rewind_cnt_c;
      end else begin
        if (alloc_fire_c) begin
          tail <= tail + TAG_W'(1);
        end
        if (alloc_fire_c && !free_fire_c) begin
          count <= count + CNT_W'(1);
        end else if (!alloc_fire_c && free_fire_c) begin
          count <= count - CNT_W'(1);
        end
      end
      if (free_fire_c) begin
        head <= head + TAG_W'(1);
      end
    end
  end

  // Redirect pulse and predictor update, both one cycle after the check.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      upd_is_branch    <= 1'b0;
      upd_is_j         <= 1'b0;
      upd_is_jal       <= 1'b0;
      upd_is_jalr      <= 1'b0;
      upd_is_jr_ra_exe <= 1'b0;
      upd_is_taken     <= 1'b0;
      upd_exe_pc       <= '0;
      upd_dest_pc      <= '0;
      upd_ret_pc       <= '0;
    end else begin
      redirect_valid   <= rewind_c;
      redirect_pc      <= rewind_c ? next_pc_c : '0;
      upd_is_branch    <= upd_en_c && res_is_branch;
      upd_is_j         <= upd_en_c && res_is_j;
      upd_is_jal       <= upd_en_c && res_is_jal;
      upd_is_jalr      <= upd_en_c && res_is_jalr;
      upd_is_jr_ra_exe <= upd_en_c && res_is_jr_ra;
      upd_is_taken     <= upd_en_c && res_taken;
      upd_exe_pc       <= upd_en_c ? res_pc : '0;
      upd_dest_pc      <= upd_en_c ? res_dest_pc : '0;
      upd_ret_pc       <= upd_en_c ? res_pc + 32'd8 : '0;
    end
  end

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Self-checking bench for bp_resolve_queue: table of single-packet check
// vectors plus hand-written fill, rewind/wrong-path and async-reset sequences.
module tb_bp_resolve_queue;
  import bp_resolve_queue_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAG_W = 3;
  localparam int unsigned NV    = 10;

  logic             clk, resetn;
  logic             alloc_valid, alloc_ready, alloc_taken, alloc_pos;
  logic [31:0]      alloc_pc, alloc_pre_pc;
  logic [TAG_W-1:0] alloc_tag;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic [31:0]      res_pc, res_dest_pc;
  logic             res_is_branch, res_is_j, res_is_jal, res_is_jalr, res_is_jr_ra, res_taken;
  logic             free_valid, fetch_restart;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             upd_is_branch, upd_is_j, upd_is_jal, upd_is_jalr, upd_is_jr_ra_exe, upd_is_taken;
  logic [31:0]      upd_exe_pc, upd_dest_pc, upd_ret_pc;
  logic             full, empty;

  bp_resolve_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
    .alloc_taken(alloc_taken), .alloc_pos(alloc_pos), .alloc_pre_pc(alloc_pre_pc),
    .alloc_tag(alloc_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_pc(res_pc),
    .res_is_branch(res_is_branch), .res_is_j(res_is_j), .res_is_jal(res_is_jal),
    .res_is_jalr(res_is_jalr), .res_is_jr_ra(res_is_jr_ra),
    .res_taken(res_taken), .res_dest_pc(res_dest_pc),
    .free_valid(free_valid), .fetch_restart(fetch_restart),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_is_branch(upd_is_branch), .upd_is_j(upd_is_j), .upd_is_jal(upd_is_jal),
    .upd_is_jalr(upd_is_jalr), .upd_is_jr_ra_exe(upd_is_jr_ra_exe),
    .upd_is_taken(upd_is_taken),
    .upd_exe_pc(upd_exe_pc), .upd_dest_pc(upd_dest_pc), .upd_ret_pc(upd_ret_pc),
    .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Kind codes: 0 none, 1 branch, 2 j, 3 jal, 4 jalr, 5 jr ra.
  // upd flags packed {branch, j, jal, jalr, jr_ra, taken}.
  typedef struct {
    logic [31:0] pc;  logic taken; logic pos; logic [31:0] pre;
    logic [31:0] rpc; logic [2:0] kind; logic rtaken; logic [31:0] dest;
    logic exp_rv; logic [31:0] exp_rpc; logic [5:0] exp_upd;
  } vec_t;

  typedef struct {
    logic rv; logic [31:0] rpc; logic [5:0] upd;
    logic [31:0] exe; logic [31:0] dest; logic [31:0] ret;
  } exp_t;

  vec_t        vecs [NV];
  exp_t        sb [$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_pc = '0; alloc_taken = 0; alloc_pos = 0; alloc_pre_pc = '0;
    res_valid = 0; res_tag = '0; res_pc = '0; res_dest_pc = '0; res_taken = 0;
    res_is_branch = 0; res_is_j = 0; res_is_jal = 0; res_is_jalr = 0; res_is_jr_ra = 0;
    free_valid = 0; fetch_restart = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    #3;
    resetn = 1;
    step();
  endtask

  task automatic alloc_one(input logic [31:0] pc, input logic tk, input logic pos,
                           input logic [31:0] pre, output logic [TAG_W-1:0] tag);
    alloc_valid = 1; alloc_pc = pc; alloc_taken = tk; alloc_pos = pos; alloc_pre_pc = pre;
    tag = alloc_tag;
    step();
    alloc_valid = 0;
  endtask

  // Drive one exe cycle, queue its expected outcome, compare one cycle later.
  task automatic res_cycle(input string name, input logic [TAG_W-1:0] tag,
                           input logic [31:0] pc, input logic [2:0] kind, input logic tk,
                           input logic [31:0] dest, input logic exp_rv,
                           input logic [31:0] exp_rpc, input logic [5:0] exp_upd);
    exp_t e;
    exp_t got;
    logic [5:0] upd;
    res_valid = 1; res_tag = tag; res_pc = pc; res_taken = tk; res_dest_pc = dest;
    res_is_branch = (kind == 3'd1); res_is_j = (kind == 3'd2); res_is_jal = (kind == 3'd3);
    res_is_jalr = (kind == 3'd4); res_is_jr_ra = (kind == 3'd5);
    e.rv = exp_rv; e.rpc = exp_rpc; e.upd = exp_upd;
    e.exe = pc; e.dest = dest; e.ret = pc + 32'd8;
    sb.push_back(e);
    step();
    res_valid = 0; res_is_branch = 0; res_is_j = 0; res_is_jal = 0;
    res_is_jalr = 0; res_is_jr_ra = 0; res_taken = 0;
    got = sb.pop_front();
    upd = {upd_is_branch, upd_is_j, upd_is_jal, upd_is_jalr, upd_is_jr_ra_exe, upd_is_taken};
    check({name, ".redirect_valid"}, 32'(redirect_valid), 32'(got.rv));
    if (got.rv) check({name, ".redirect_pc"}, redirect_pc, got.rpc);
    check({name, ".upd_flags"}, 32'(upd), 32'(got.upd));
    if (got.upd != 6'b0) begin
      check({name, ".upd_exe_pc"}, upd_exe_pc, got.exe);
      check({name, ".upd_dest_pc"}, upd_dest_pc, got.dest);
      check({name, ".upd_ret_pc"}, upd_ret_pc, got.ret);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [TAG_W-1:0] tag;

    vecs[0] = '{32'h100, 1'b1, 1'b1, 32'h200, 32'h104, 3'd1, 1'b1, 32'h200, 1'b0, 32'h0,    6'b100001};
    vecs[1] = '{32'h100, 1'b0, 1'b0, 32'h0,   32'h100, 3'd1, 1'b1, 32'h300, 1'b1, 32'h300,  6'b100001};
    vecs[2] = '{32'h100, 1'b1, 1'b0, 32'h200, 32'h100, 3'd4, 1'b1, 32'h240, 1'b1, 32'h240,  6'b000101};
    vecs[3] = '{32'h100, 1'b1, 1'b0, 32'h200, 32'h100, 3'd1, 1'b0, 32'h200, 1'b1, 32'h108,  6'b100000};
    vecs[4] = '{32'h100, 1'b1, 1'b1, 32'h200, 32'h100, 3'd1, 1'b0, 32'h0,   1'b0, 32'h0,    6'b100000};
    vecs[5] = '{32'h100, 1'b0, 1'b0, 32'h0,   32'h100, 3'd0, 1'b0, 32'h0,   1'b0, 32'h0,    6'b000000};
    vecs[6] = '{32'h100, 1'b1, 1'b0, 32'h200, 32'h100, 3'd0, 1'b0, 32'h0,   1'b1, 32'h104,  6'b000000};
    vecs[7] = '{32'h400, 1'b1, 1'b1, 32'h800, 32'h404, 3'd5, 1'b1, 32'h800, 1'b0, 32'h0,    6'b000011};
    vecs[8] = '{32'h500, 1'b0, 1'b0, 32'h0,   32'h504, 3'd3, 1'b1, 32'h1000,1'b1, 32'h1000, 6'b001001};
    vecs[9] = '{32'h100, 1'b0, 1'b0, 32'h0,   32'h104, 3'd2, 1'b1, 32'h180, 1'b1, 32'h180,  6'b010001};

    // Reset values while reset is held.
    idle();
    resetn = 0;
    #12;
    check("rst.alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.full", 32'(full), 32'd0);
    check("rst.redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst.upd_is_branch", 32'(upd_is_branch), 32'd0);
    check("rst.alloc_tag", 32'(alloc_tag), 32'd0);
    resetn = 1;
    step();

    // Single-packet check vectors.
    for (int i = 0; i < NV; i++) begin
      alloc_one(vecs[i].pc, vecs[i].taken, vecs[i].pos, vecs[i].pre, tag);
      res_cycle($sformatf("vec%0d", i), tag, vecs[i].rpc, vecs[i].kind, vecs[i].rtaken,
                vecs[i].dest, vecs[i].exp_rv, vecs[i].exp_rpc, vecs[i].exp_upd);
      if (vecs[i].exp_rv) begin
        step();
        check($sformatf("vec%0d.wait_ready", i), 32'(alloc_ready), 32'd0);
        fetch_restart = 1;
        step();
        fetch_restart = 0;
        check($sformatf("vec%0d.run_ready", i), 32'(alloc_ready), 32'd1);
      end
      free_valid = 1;
      step();
      free_valid = 0;
      check($sformatf("vec%0d.empty", i), 32'(empty), 32'd1);
    end

    // Fill to full, refused 9th alloc must not overwrite, then reuse of tag 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill.tag%0d", i), 32'(alloc_tag), 32'(i));
      alloc_one(32'h1000 + 32'(i) * 32'h10, 1'b0, 1'b0, 32'h0, tag);
    end
    check("fill.full", 32'(full), 32'd1);
    check("fill.alloc_ready", 32'(alloc_ready), 32'd0);
    alloc_one(32'h1000, 1'b1, 1'b0, 32'h9999, tag);
    check("fill.refused_tag", 32'(alloc_tag), 32'd0);
    check("fill.still_full", 32'(full), 32'd1);
    res_cycle("fill.no_overwrite", 3'd0, 32'h1000, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 6'b0);
    free_valid = 1;
    step();
    free_valid = 0;
    check("fill.free_full", 32'(full), 32'd0);
    check("fill.free_ready", 32'(alloc_ready), 32'd1);
    check("fill.reuse_tag", 32'(alloc_tag), 32'd0);
    alloc_one(32'h2000, 1'b0, 1'b0, 32'h0, tag);
    check("fill.realloc_tag", 32'(alloc_tag), 32'd1);
    check("fill.refull", 32'(full), 32'd1);

    // Rewind with same-cycle free and alloc, then wrong-path suppression.
    do_reset();
    alloc_one(32'h100, 1'b0, 1'b0, 32'h0, tag);
    alloc_one(32'h200, 1'b0, 1'b0, 32'h0, tag);
    alloc_one(32'h300, 1'b1, 1'b0, 32'h500, tag);
    alloc_one(32'h400, 1'b0, 1'b0, 32'h0, tag);
    free_valid = 1;
    alloc_valid = 1; alloc_pc = 32'h777;
    res_cycle("rw.miss", 3'd1, 32'h200, 3'd1, 1'b1, 32'h300, 1'b1, 32'h300, 6'b100001);
    free_valid = 0;
    alloc_valid = 0;
    check("rw.tail", 32'(alloc_tag), 32'd2);
    check("rw.alloc_ready", 32'(alloc_ready), 32'd0);
    check("rw.not_empty", 32'(empty), 32'd0);
    res_cycle("rw.wrong_redirect", 3'd2, 32'h300, 3'd1, 1'b0, 32'h0, 1'b0, 32'h0, 6'b0);
    res_cycle("rw.wrong_wait", 3'd2, 32'h300, 3'd1, 1'b0, 32'h0, 1'b0, 32'h0, 6'b0);
    check("rw.wait_ready", 32'(alloc_ready), 32'd0);
    fetch_restart = 1;
    step();
    fetch_restart = 0;
    check("rw.restart_ready", 32'(alloc_ready), 32'd1);
    check("rw.restart_tag", 32'(alloc_tag), 32'd2);
    free_valid = 1;
    step();
    free_valid = 0;
    check("rw.drain_empty", 32'(empty), 32'd1);

    // Async reset in WAIT clears state without a clock edge.
    alloc_one(32'h100, 1'b0, 1'b0, 32'h0, tag);
    res_cycle("ar.miss", tag, 32'h100, 3'd1, 1'b1, 32'h300, 1'b1, 32'h300, 6'b100001);
    step();
    check("ar.wait_ready", 32'(alloc_ready), 32'd0);
    #2;
    resetn = 0;
    #1;
    check("ar.alloc_ready", 32'(alloc_ready), 32'd1);
    check("ar.empty", 32'(empty), 32'd1);
    check("ar.alloc_tag", 32'(alloc_tag), 32'd0);
    check("ar.redirect_valid", 32'(redirect_valid), 32'd0);
    #1;
    resetn = 1;
    step();
    check("ar.run_ready", 32'(alloc_ready), 32'd1);
    alloc_one(32'h100, 1'b0, 1'b0, 32'h0, tag);
    check("ar.first_tag", 32'(tag), 32'd0);
    check("ar.occupied", 32'(empty), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
